// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Build option: MEMORY_ARBITER_DUAL_ISSUE_EN (see memory_arbiter.sv).
package memory_arbiter_pkg;

   // Lock FSM: idle round-robin, or bus held by port 0 / port 1
   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_LOCK0 = 2'd1,
      ARB_LOCK1 = 2'd2
   } arb_state_t;

   // Requester indices into the valid/grant vectors
   localparam int PORT_CPU    = 0;
   localparam int PORT_LOADER = 1;

   // Lock counter width; the extra bit keeps the counter from ever wrapping
   function automatic int lock_cnt_width(input int lock_max);
      return $clog2(lock_max) + 1;
   endfunction

endpackage

// File: rtl/memory_arbiter_rr.sv
// Two-way round-robin picker. Produces a one-hot grant among the requesters
// that are both valid and allowed; on contention the port that did not win
// last time is chosen.
module memory_arbiter_rr
   import memory_arbiter_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       last_grant,
   input  logic [1:0] allow,
   output logic [1:0] grant
);

   logic [1:0] eligible;

   // Mask requests, then break a tie in favour of the port that lost last time
   always_comb begin
      eligible = valid & allow;
      grant    = eligible;
      if (eligible == 2'b11) begin
         grant                = 2'b00;
         grant[PORT_CPU]      = last_grant;
         grant[PORT_LOADER]   = ~last_grant;
      end
   end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one simple-dual-port memory between a CPU port (0) and a loader/DMA
// port (1). Round-robin arbitration, bounded bus lock for bursts, 1-cycle
// read response latency.
// Build option: define MEMORY_ARBITER_DUAL_ISSUE_EN to let a read on one
// port and a write on the other (different addresses) issue together while
// idle. Requests carrying a lock flag never dual-issue, so that lock entry
// always belongs to exactly one port.
module memory_arbiter
   import memory_arbiter_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 12,
   parameter int DATA_WIDTH    = 32,
   parameter int LOCK_MAX      = 16
)(
   input  logic                     clka,
   input  logic                     rsta,
   input  logic                     req_valid_0,
   input  logic                     req_write_0,
   input  logic                     req_lock_0,
   input  logic [ADDRESS_WIDTH-1:0] req_address_0,
   input  logic [DATA_WIDTH-1:0]    req_wdata_0,
   input  logic                     req_valid_1,
   input  logic                     req_write_1,
   input  logic                     req_lock_1,
   input  logic [ADDRESS_WIDTH-1:0] req_address_1,
   input  logic [DATA_WIDTH-1:0]    req_wdata_1,
   output logic                     req_ready_0,
   output logic                     req_ready_1,
   output logic                     rsp_valid_0,
   output logic [DATA_WIDTH-1:0]    rsp_data_0,
   output logic                     rsp_valid_1,
   output logic [DATA_WIDTH-1:0]    rsp_data_1,
   output logic                     mem_enable_read,
   output logic [ADDRESS_WIDTH-1:0] mem_read_address,
   output logic                     mem_enable_write,
   output logic [ADDRESS_WIDTH-1:0] mem_write_address,
   output logic [DATA_WIDTH-1:0]    mem_write_data,
   input  logic [DATA_WIDTH-1:0]    mem_read_data
);

   localparam int                CNT_W    = lock_cnt_width(LOCK_MAX);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LOCK_MAX - 1);

   arb_state_t        state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
   logic [1:0]        rsp_pend_q, rsp_pend_d;

   logic [1:0] valid;
   logic [1:0] allow;
   logic [1:0] rr_grant;
   logic [1:0] grant;
   logic [1:0] accept;
   logic [1:0] is_write;
   logic [1:0] rd_acc;
   logic [1:0] wr_acc;
   logic       dual_ok;

   assign valid    = {req_valid_1, req_valid_0};
   assign is_write = {req_write_1, req_write_0};

   // A lock restricts eligibility to its owner, even when the owner is idle
   always_comb begin
      allow = 2'b11;
      case (state_q)
         ARB_LOCK0: allow = 2'b01;
         ARB_LOCK1: allow = 2'b10;
         default:   allow = 2'b11;
      endcase
   end

   memory_arbiter_rr u_rr (
      .valid      (valid),
      .last_grant (last_grant_q),
      .allow      (allow),
      .grant      (rr_grant)
   );

   // Decide whether a read/write pair may share the cycle (optional feature)
   always_comb begin
`ifdef MEMORY_ARBITER_DUAL_ISSUE_EN
      dual_ok = (state_q == ARB_IDLE) && req_valid_0 && req_valid_1 &&
                (req_write_0 != req_write_1) &&
                (req_address_0 != req_address_1) &&
                !req_lock_0 && !req_lock_1;
`else
      dual_ok = 1'b0;
`endif
   end

   // Final grant, suppressed while reset is held
   always_comb begin
      grant  = dual_ok ? 2'b11 : rr_grant;
      if (rsta) begin
         grant = 2'b00;
      end
      accept = valid & grant;
      rd_acc = accept & ~is_write;
      wr_acc = accept & is_write;
   end

   assign req_ready_0 = grant[PORT_CPU];
   assign req_ready_1 = grant[PORT_LOADER];

   // Steer the accepted read and/or write onto the memory pins
   always_comb begin
      mem_enable_read   = |rd_acc;
      mem_read_address  = rd_acc[PORT_LOADER] ? req_address_1 : req_address_0;
      mem_enable_write  = |wr_acc;
      mem_write_address = wr_acc[PORT_LOADER] ? req_address_1 : req_address_0;
      mem_write_data    = wr_acc[PORT_LOADER] ? req_wdata_1 : req_wdata_0;
   end

   // Next-state logic: round-robin history, lock FSM and read-response tag
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      lock_cnt_d   = lock_cnt_q;
      rsp_pend_d   = rd_acc;

      if (accept == 2'b01) begin
         last_grant_d = 1'b0;
      end else if (accept == 2'b10) begin
         last_grant_d = 1'b1;
      end

      case (state_q)
         ARB_IDLE: begin
            lock_cnt_d = '0;
            if (accept[PORT_CPU] && req_lock_0) begin
               state_d = ARB_LOCK0;
            end else if (accept[PORT_LOADER] && req_lock_1) begin
               state_d = ARB_LOCK1;
            end
         end
         ARB_LOCK0: begin
            lock_cnt_d = lock_cnt_q + CNT_W'(1);
            if ((accept[PORT_CPU] && !req_lock_0) || (lock_cnt_q == CNT_LAST)) begin
               state_d      = ARB_IDLE;
               lock_cnt_d   = '0;
               last_grant_d = 1'b0;
            end
         end
         ARB_LOCK1: begin
            lock_cnt_d = lock_cnt_q + CNT_W'(1);
            if ((accept[PORT_LOADER] && !req_lock_1) || (lock_cnt_q == CNT_LAST)) begin
               state_d      = ARB_IDLE;
               lock_cnt_d   = '0;
               last_grant_d = 1'b1;
            end
         end
         default: begin
            state_d    = ARB_IDLE;
            lock_cnt_d = '0;
         end
      endcase
   end

   // State registers; reset drops any in-flight read response
   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
         state_q      <= ARB_IDLE;
         last_grant_q <= 1'b1;
         lock_cnt_q   <= '0;
         rsp_pend_q   <= 2'b00;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         lock_cnt_q   <= lock_cnt_d;
         rsp_pend_q   <= rsp_pend_d;
      end
   end

   assign rsp_valid_0 = rsp_pend_q[PORT_CPU];
   assign rsp_valid_1 = rsp_pend_q[PORT_LOADER];
   assign rsp_data_0  = mem_read_data;
   assign rsp_data_1  = mem_read_data;

endmodule
